// File: rtl/chan_mux_reg.sv
// Registered N-channel selector with valid/ready output stage, round-robin scan
// mode, per-word channel tag and saturating out-of-range select counter.
module chan_mux_reg #(
  parameter int WIDTH = 4,
  parameter int NCH   = 6,
  parameter int SELW  = 3,
  parameter int ECNTW = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0]   data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_chan,
  output logic                   sel_err,
  output logic [ECNTW-1:0]       err_cnt
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ch;
  logic             in_range;
  logic [WIDTH-1:0] ch_data;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Compare in 32-bit space so NCH == 2**SELW still works.
  always_comb begin
    ch       = mode ? ptr : sel;
    in_range = (int'(ch) < NCH);
    ch_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == SELW'(k)) ch_data = data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
      err_cnt   <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_chan  <= ch;
        if (in_range) begin
          out     <= ch_data;
          sel_err <= 1'b0;
        end else begin
          out     <= '0;
          sel_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ECNTW'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Manual mode parks the pointer so every scan session starts at channel 0.
      if (!mode) begin
        ptr <= '0;
      end else if (accept) begin
        if (ptr == SELW'(NCH-1)) ptr <= '0;
        else                     ptr <= ptr + SELW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_reg.sv
// Scoreboard bench for chan_mux_reg: driver pushes expected words from a
// behavioural model, an independent monitor checks whatever the DUT presents.
module tb_chan_mux_reg;
  localparam int WIDTH = 4;
  localparam int NCH   = 6;
  localparam int SELW  = 3;
  localparam int ECNTW = 8;
  localparam int EMAX  = 255;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] data;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_chan;
  logic                 sel_err;
  logic [ECNTW-1:0]     err_cnt;

  chan_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .ECNTW(ECNTW)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .sel(sel), .data(data),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int c;
    int e;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: whether a word is held, scan position, error count.
  int   m_valid;
  int   m_ptr;
  int   m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_word", 1, 0);
      end else begin
        chk("sb_out", int'(out), q[0].d);
        chk("sb_chan", int'(out_chan), q[0].c);
        chk("sb_err", int'(sel_err), q[0].e);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic m, input logic [SELW-1:0] s,
                       input logic [NCH*WIDTH-1:0] d, input logic iv, input logic ordy);
    int acc, xfer, ch;
    exp_t e;
    mode = m; sel = s; data = d; in_valid = iv; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", int'(in_ready), (m_valid == 0 || ordy) ? 1 : 0);
    chk("out_valid", int'(out_valid), m_valid);
    chk("err_cnt", int'(err_cnt), m_err);
    acc  = (iv && (m_valid == 0 || ordy)) ? 1 : 0;
    xfer = (m_valid != 0 && ordy) ? 1 : 0;
    if (acc != 0) begin
      ch = m ? m_ptr : int'(s);
      if (ch < NCH) begin
        e.d = int'(d[ch*WIDTH +: WIDTH]); e.c = ch; e.e = 0;
      end else begin
        e.d = 0; e.c = int'(s); e.e = 1;
        m_err = (m_err + 1 > EMAX) ? EMAX : m_err + 1;
      end
      q.push_back(e);
      m_valid = 1;
    end else if (xfer != 0) begin
      m_valid = 0;
    end
    if (!m) m_ptr = 0;
    else if (acc != 0) m_ptr = (m_ptr + 1) % NCH;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    q.delete();
    m_valid = 0; m_ptr = 0; m_err = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_sel_err", int'(sel_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  function automatic logic [NCH*WIDTH-1:0] ramp(input int base);
    logic [NCH*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    return v;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] rnd_data();
    return (NCH*WIDTH)'({$urandom, $urandom});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*WIDTH-1:0] d;
    mode = 1'b0; sel = '0; data = '0; in_valid = 1'b0; out_ready = 1'b0; resetn = 1'b0;
    m_valid = 0; m_ptr = 0; m_err = 0;
    @(posedge clk); #1;
    do_reset();

    // Manual select of channel 2.
    d = rnd_data();
    d[2*WIDTH +: WIDTH] = 4'hA;
    drive(1'b0, 3'd2, d, 1'b1, 1'b1);
    chk("man_out", int'(out), 10);
    chk("man_chan", int'(out_chan), 2);
    chk("man_valid", int'(out_valid), 1);
    chk("man_err", int'(sel_err), 0);

    // Out-of-range selects, then saturation.
    drive(1'b0, 3'd6, rnd_data(), 1'b1, 1'b1);
    chk("oor6_err", int'(sel_err), 1);
    drive(1'b0, 3'd7, rnd_data(), 1'b1, 1'b1);
    chk("oor7_err", int'(sel_err), 1);
    chk("oor_out", int'(out), 0);
    chk("err_cnt_two", int'(err_cnt), 2);
    for (int i = 0; i < 300; i++)
      drive(1'b0, 3'($urandom_range(6, 7)), rnd_data(), 1'b1, 1'b1);
    drive(1'b0, 3'd0, rnd_data(), 1'b0, 1'b1);
    chk("err_cnt_sat", int'(err_cnt), 255);

    // Round-robin scan with channel k holding k+1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'($urandom), ramp(1), 1'b1, 1'b1);
      chk("scan_chan", int'(out_chan), i % NCH);
      chk("scan_out", int'(out), (i % NCH) + 1);
    end
    drive(1'b0, 3'd0, rnd_data(), 1'b0, 1'b1);

    // Backpressure: freeze for 3 cycles while inputs wander.
    drive(1'b0, 3'd4, rnd_data(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(1'($urandom), 3'($urandom), rnd_data(), 1'b1, 1'b0);
    drive(1'b0, 3'd1, rnd_data(), 1'b1, 1'b1);
    chk("bp_reload_valid", int'(out_valid), 1);
    chk("bp_reload_chan", int'(out_chan), 1);
    drive(1'b0, 3'd0, rnd_data(), 1'b0, 1'b1);

    // Scan to ptr=3, one manual cycle, then resume from channel 0.
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd0, ramp(1), 1'b1, 1'b1);
    drive(1'b0, 3'd5, rnd_data(), 1'b0, 1'b1);
    drive(1'b1, 3'd5, ramp(1), 1'b1, 1'b1);
    chk("scan_restart", int'(out_chan), 0);
    drive(1'b1, 3'd0, ramp(1), 1'b0, 1'b1);

    // Reset with a held word and err_cnt=5.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 3'd7, rnd_data(), 1'b1, 1'b1);
    drive(1'b0, 3'd3, rnd_data(), 1'b1, 1'b0);
    drive(1'b0, 3'd3, rnd_data(), 1'b0, 1'b0);
    chk("pre_rst_err_cnt", int'(err_cnt), 5);
    do_reset();
    drive(1'b1, 3'd4, ramp(7), 1'b1, 1'b1);
    chk("post_rst_scan_chan", int'(out_chan), 0);
    chk("post_rst_scan_out", int'(out), 7);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom), 3'($urandom_range(0, 7)), rnd_data(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, rnd_data(), 1'b0, 1'b1);
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
